// File: rtl/jtcontra_gfx_pkg.sv
// jtcontra_gfx_pkg: shared constants and pixel helpers for the tile line buffer.
package jtcontra_gfx_pkg;
  localparam int LINE_AW = 9;
  localparam logic [3:0] TRANSP_COLOUR = 4'h0;
  localparam int PAL_MSB = 7;
  localparam int PAL_LSB = 4;
  localparam int COL_MSB = 3;
  localparam int COL_LSB = 0;
  typedef logic [LINE_AW:0] lbuf_addr_t;
  function automatic logic opaque(input logic [7:0] b);
    return b[COL_MSB:COL_LSB] != TRANSP_COLOUR;
  endfunction
endpackage

// File: rtl/jtcontra_gfx_linebuf_if.sv
// jtcontra_gfx_linebuf_if: renderer-to-line-buffer write bus.
interface jtcontra_gfx_linebuf_if;
  import jtcontra_gfx_pkg::*;
  logic line;
  logic chr_we;
  logic scr_we;
  logic [7:0] line_din;
  lbuf_addr_t line_addr;
  modport master(output line, chr_we, scr_we, line_din, line_addr);
  modport slave(input line, chr_we, scr_we, line_din, line_addr);
endinterface

// File: rtl/jtcontra_linebuf_dpram.sv
// jtcontra_linebuf_dpram: 1024x8 dual-port RAM, port A write-only, port B read with optional write.
module jtcontra_linebuf_dpram
  import jtcontra_gfx_pkg::*;
(
  input  logic       clk,
  input  logic       we_a,
  input  lbuf_addr_t addr_a,
  input  logic [7:0] din_a,
  input  logic       we_b,
  input  lbuf_addr_t addr_b,
  input  logic [7:0] din_b,
  output logic [7:0] dout_b
);
  logic [7:0] mem [2**(LINE_AW+1)];
  logic [7:0] dout_q;
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
    dout_q <= mem[addr_b];
  end
  assign dout_b = dout_q;
endmodule

// File: rtl/jtcontra_gfx_linebuf.sv
// jtcontra_gfx_linebuf: double-buffered chr/scroll line RAMs, scan-out and transparency merge.
// Define JTCONTRA_LINEBUF_CLR_EN to erase each location in the clk after it is read.
module jtcontra_gfx_linebuf
  import jtcontra_gfx_pkg::*;
#(
  parameter logic [LINE_AW-1:0] HOFFSET   = 9'd0,
  parameter logic [7:0]         BLANK_PXL = 8'h00
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pxl_cen,
  input  logic                         LHBL,
  input  logic                         LVBL,
  jtcontra_gfx_linebuf_if.slave        wr,
  output logic [7:0]                   pxl,
  output logic                         pxl_lyr
);
  logic [LINE_AW-1:0] hcnt_q, hcnt_d;
  logic rd_half_q, rd_half_d, rd_vld_q, rd_vld_d, last_lhbl_q;
  logic [7:0] pxl_q, pxl_d;
  logic lyr_q, lyr_d;
  logic rise, issue, blank, chr_win, port_we;
  lbuf_addr_t rd_addr, port_addr;
  logic [7:0] chr_dout, scr_dout;
`ifdef JTCONTRA_LINEBUF_CLR_EN
  lbuf_addr_t clr_addr_q, clr_addr_d;
`endif
  // Clearing borrows port B in the capture clk, so pxl_cen pulses must be at least 2 clk apart.
  always_comb begin
    rise = LHBL & ~last_lhbl_q;
    issue = pxl_cen & LHBL & LVBL & ~rise;
    blank = ~LHBL | ~LVBL;
    rd_addr = {rd_half_q, hcnt_q};
    chr_win = opaque(chr_dout);
    hcnt_d = rise ? HOFFSET : issue ? hcnt_q + LINE_AW'(1) : hcnt_q;
    rd_half_d = rise ? ~wr.line : rd_half_q;
    rd_vld_d = issue;
    pxl_d = blank ? BLANK_PXL : rd_vld_q ? (chr_win ? chr_dout : scr_dout) : pxl_q;
    lyr_d = ~blank & (rd_vld_q ? chr_win : lyr_q);
`ifdef JTCONTRA_LINEBUF_CLR_EN
    clr_addr_d = issue ? rd_addr : clr_addr_q;
    port_addr = rd_vld_q ? clr_addr_q : rd_addr;
    port_we = rd_vld_q;
`else
    port_addr = rd_addr;
    port_we = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= HOFFSET;
      rd_half_q <= 1'b0;
      rd_vld_q <= 1'b0;
      last_lhbl_q <= 1'b1;
      pxl_q <= BLANK_PXL;
      lyr_q <= 1'b0;
`ifdef JTCONTRA_LINEBUF_CLR_EN
      clr_addr_q <= '0;
`endif
    end else begin
      hcnt_q <= hcnt_d;
      rd_half_q <= rd_half_d;
      rd_vld_q <= rd_vld_d;
      last_lhbl_q <= LHBL;
      pxl_q <= pxl_d;
      lyr_q <= lyr_d;
`ifdef JTCONTRA_LINEBUF_CLR_EN
      clr_addr_q <= clr_addr_d;
`endif
    end
  end
  jtcontra_linebuf_dpram u_chr (
    .clk(clk), .we_a(wr.chr_we), .addr_a(wr.line_addr), .din_a(wr.line_din),
    .we_b(port_we), .addr_b(port_addr), .din_b(8'h00), .dout_b(chr_dout)
  );
  jtcontra_linebuf_dpram u_scr (
    .clk(clk), .we_a(wr.scr_we), .addr_a(wr.line_addr), .din_a(wr.line_din),
    .we_b(port_we), .addr_b(port_addr), .din_b(8'h00), .dout_b(scr_dout)
  );
  assign pxl = pxl_q;
  assign pxl_lyr = lyr_q;
endmodule

// File: tb/tb_jtcontra_gfx_linebuf.sv
// tb_jtcontra_gfx_linebuf: randomized scoreboard bench against a line-buffer reference model.
module tb_jtcontra_gfx_linebuf;
  logic clk = 0, rst = 1, pxl_cen = 0, LHBL = 0, LVBL = 1;
  logic [7:0] pxl;
  logic pxl_lyr;
  jtcontra_gfx_linebuf_if wr();
  jtcontra_gfx_linebuf dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .wr(wr), .pxl(pxl), .pxl_lyr(pxl_lyr)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int due; logic [7:0] px; logic lyr;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, fill = 0;
  logic [7:0] chr_m [1024];
  logic [7:0] scr_m [1024];
  logic rh = 0, ln = 0;
  logic [8:0] x = 0;
  always @(negedge clk)
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (pxl !== e.px || pxl_lyr !== e.lyr) begin
        n_bad++;
        $display("FAIL pixel cyc=%0d got pxl=%h lyr=%b want pxl=%h lyr=%b", cyc, pxl, pxl_lyr, e.px, e.lyr);
      end
    end
  task automatic step(input logic cen);
    pxl_cen = cen;
    @(posedge clk);
    #1;
    pxl_cen = 0;
    wr.chr_we = 0;
    wr.scr_we = 0;
  endtask
  task automatic expect_px(input int dly, input logic [7:0] p, input logic l);
    q.push_back('{cyc + dly, p, l});
  endtask
  task automatic wr_set(input logic c, input logic s, input logic [9:0] a, input logic [7:0] d);
    wr.chr_we = c;
    wr.scr_we = s;
    wr.line_addr = a;
    wr.line_din = d;
    if (c) chr_m[a] = d;
    if (s) scr_m[a] = d;
  endtask
  function automatic logic [7:0] rnd_px();
    logic [7:0] v;
    v = 8'($urandom);
    if ($urandom_range(1, 0) == 1) v[3:0] = 4'h0;
    return v;
  endfunction
  task automatic pix();
    logic [9:0] a;
    a = {rh, x};
    if (chr_m[a][3:0] != 4'h0) expect_px(2, chr_m[a], 1'b1);
    else expect_px(2, scr_m[a], 1'b0);
`ifdef JTCONTRA_LINEBUF_CLR_EN
    chr_m[a] = 8'h00;
    scr_m[a] = 8'h00;
`endif
    x = x + 9'd1;
    step(1);
  endtask
  task automatic render(input int mode);
    if (mode == 1 && $urandom_range(1, 0) == 1)
      wr_set(1'($urandom), 1'($urandom), {ln, 9'($urandom)}, rnd_px());
    else if (mode == 2 && fill < 512) begin
      wr_set(1, 1, {ln, 9'(fill)}, 8'hFF);
      fill++;
    end
  endtask
  task automatic start_line(input logic l, input logic cen);
    ln = l;
    wr.line = l;
    LHBL = 1;
    if (cen) expect_px(2, 8'h00, 1'b0);
    step(cen);
    rh = ~l;
    x = 9'd0;
  endtask
  task automatic scan(input int n, input int mode, input int gap);
    for (int i = 0; i < n; i++) begin
      render(mode);
      pix();
      repeat (gap > 0 ? gap : $urandom_range(3, 1)) begin
        render(mode);
        step(0);
      end
    end
  endtask
  task automatic end_line(input int n);
    LHBL = 0;
    expect_px(2, 8'h00, 1'b0);
    repeat (n) step(0);
  endtask
  task automatic prep(input logic l, input int n);
    repeat (n) begin
      wr_set(1'($urandom), 1'($urandom), {~l, 9'($urandom)}, rnd_px());
      step(0);
    end
  endtask
  initial begin
    wr.line = 0;
    wr.chr_we = 0;
    wr.scr_we = 0;
    wr.line_din = 0;
    wr.line_addr = 0;
    repeat (4) begin
      expect_px(2, 8'h00, 1'b0);
      step(1'($urandom));
    end
    rst = 0;
    for (int a = 0; a < 1024; a++) begin
      wr_set(1, 1, 10'(a), rnd_px());
      step(0);
    end
    expect_px(2, 8'h00, 1'b0);
    step(0);
    // transparency: scroll shows through a colour-0 chr pixel, then opaque chr wins
    wr_set(1, 0, 10'd5, 8'h30); step(0);
    wr_set(0, 1, 10'd5, 8'h47); step(0);
    start_line(1, 0); scan(6, 1, 0); end_line(3);
    wr_set(1, 0, 10'd5, 8'h3A); step(0);
    start_line(1, 0); scan(6, 1, 0); end_line(3);
    // re-reading an unwritten half shows whether reads erase
    wr_set(1, 0, 10'd5, 8'h30); step(0);
    wr_set(0, 1, 10'd5, 8'h47); step(0);
    start_line(1, 0); scan(8, 0, 0); end_line(3);
    start_line(1, 0); scan(8, 0, 0); end_line(3);
    // latency, with pxl_cen coinciding with the LHBL rise
    wr_set(1, 0, {1'b1, 9'd0}, 8'h00); step(0);
    wr_set(0, 1, {1'b1, 9'd0}, 8'h12); step(0);
    start_line(0, 1);
    expect_px(1, 8'h00, 1'b0);
    pix(); step(0); step(0);
    end_line(2);
    // half isolation and hcnt wrap
    fill = 0;
    start_line(1, 0); scan(520, 2, 1); end_line(3);
    start_line(0, 0); scan(20, 1, 0); end_line(3);
    // vertical blank mid-line
    prep(1, 20);
    start_line(1, 0); scan(10, 1, 0);
    LVBL = 0;
    repeat (3) begin
      expect_px(2, 8'h00, 1'b0);
      step(1); step(0);
    end
    LVBL = 1;
    scan(10, 1, 0);
    // reset mid-line
    rst = 1;
    expect_px(2, 8'h00, 1'b0);
    step(1); step(1);
    rst = 0;
    LHBL = 0;
    expect_px(2, 8'h00, 1'b0);
    step(0); step(0); step(0);
    prep(0, 20);
    start_line(0, 0); scan(30, 1, 0); end_line(3);
    repeat (8) begin
      logic l;
      l = 1'($urandom);
      prep(l, 30);
      start_line(l, 1'($urandom));
      scan(40, 1, 0);
      end_line(3);
    end
    repeat (5) step(0);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/jtcontra_gfx_linebuf.md
Name: jtcontra_gfx_linebuf

Overview:
- Scan-out end of the tile renderer's line-buffer write interface.
- Owns two double-buffered line RAMs, one for the fixed character layer and one for the scroll layer, each 2×512 bytes.
- Accepts the renderer's write strobes. Reads the half the renderer is not filling, one pixel per pixel-clock enable.
- Merges the two layers by transparency, outputs an 8-bit palette index, and optionally erases each location after it is read.

Parameters:
- HOFFSET, 9'd0, hcnt load value at start of active line; aligns buffer address 0 with the first visible pixel.
- BLANK_PXL, 8'h00, value driven on pxl during blanking.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pxl_cen  in  1  pixel clock enable, one clk wide
- LHBL  in  1  horizontal blank, active low
- LVBL  in  1  vertical blank, active low
- line  in  1  half currently written by the renderer
- chr_we  in  1  write strobe, character layer
- scr_we  in  1  write strobe, scroll layer
- line_din  in  8  {pal[3:0], colour[3:0]}
- line_addr  in  10  {half, x[8:0]}
- pxl  out  8  merged palette index, registered
- pxl_lyr  out  1  1 = character layer won, 0 = scroll layer or blank

Behaviour:
- Reset values: pxl=BLANK_PXL, pxl_lyr=0, hcnt=HOFFSET, rd_half=0, rd_vld=0.
- Write port:
  - chr_we writes line_din to chr RAM[line_addr] on that clk; scr_we does the same to scr RAM.
  - Both may assert in the same cycle.
  - No handshake; writes are always accepted.
- Line start:
  - Detect LHBL rising edge (registered last_LHBL).
  - On that clk: hcnt<=HOFFSET, rd_half<=~line.
  - rd_half stays frozen for the whole line.
  - Renderer writes and reader reads therefore never target the same half.
- Read address:
  - rd_addr={rd_half,hcnt}.
  - On each pxl_cen with LHBL=1: issue a read, set rd_vld<=1, then hcnt<=hcnt+1.
  - hcnt wraps 511→0 silently.
- RAM read is synchronous, 1 clk. Data is captured in the clk after the read issue.
- Merge, in the capture clk:
  - If chr colour[3:0]!=0: pxl<=chr byte, pxl_lyr<=1.
  - Else: pxl<=scr byte, pxl_lyr<=0.
  - Scroll colour 0 passes through unchanged as background.
- Latency: the pixel addressed at pxl_cen N appears on pxl 2 clk later and holds until the next capture.
- Blanking:
  - Evaluate !LHBL || !LVBL at the capture clk.
  - If true: pxl<=BLANK_PXL, pxl_lyr<=0, no read issued.
- Simultaneous LHBL rise and pxl_cen:
  - The address load takes priority.
  - The first read uses HOFFSET on the next pxl_cen.
- Reset mid-line:
  - Reader outputs return to reset values.
  - RAM contents are not cleared.
  - rd_half resyncs at the next LHBL rise.
- pxl_cen with LHBL=0: no read, no clear, hcnt unchanged.

Optional Feature:
- Macro: JTCONTRA_LINEBUF_CLR_EN.
- Defined:
  - In the capture clk, the read port writes 8'h00 to rd_addr in both RAMs, so read and clear happen on the same port.
  - Pixels the renderer skips on the next use of that half read as transparent.
  - Clear never conflicts with renderer writes, because the halves differ.
- Undefined:
  - Read port is read-only.
  - Stale data persists until overwritten.

Decomposition:
- Shared package/header jtcontra_gfx_pkg:
  - LINE_AW=9
  - TRANSP_COLOUR=4'h0
  - pixel byte field positions: PAL_MSB=7, PAL_LSB=4, COL_MSB=3, COL_LSB=0
- Sub-module jtcontra_linebuf_dpram:
  - 1024×8 true dual-port RAM.
  - Port A write-only; port B read with optional write.
  - Instantiated twice (chr, scr).

Test Plan:
1. Reset then idle: rst=1 for 4 clk, LHBL=0 → pxl=8'h00, pxl_lyr=0 throughout.
2. Transparency:
   - line=0; write chr[{0,5}]=8'h30, scr[{0,5}]=8'h47.
   - Toggle line to 1 at LHBL rise; clock 6 pxl_cen.
   - Pixel 5 → pxl=8'h47, pxl_lyr=0.
   - Rewrite chr=8'h3A in the next frame → pxl=8'h3A, pxl_lyr=1.
3. Latency: single pxl_cen after LHBL rise with scr[{~line,0}]=8'h12 → pxl=8'h12 exactly 2 clk after that pxl_cen.
4. Half isolation: while the reader scans half 1, renderer writes 8'hFF to every half-0 address → scanned pixels unchanged; next line shows 8'hFF.
5. Clear (with JTCONTRA_LINEBUF_CLR_EN): read a line containing 8'h47 at x=5, then re-read the same half with no writes → pxl=8'h00 at x=5. Without the macro → 8'h47 again.
6. Blanking/reset: assert LVBL=0 mid-line → pxl=BLANK_PXL from the next capture. Assert rst mid-line → pxl=8'h00, and normal output resumes after the next LHBL rise.
